// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer: state encoding,
// stage indices and the per-stage pass-count lookup.
package cnn_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_NEXT,
      S_FINISH
   } seq_state_t;

   localparam int NUM_STAGES = 6;
   localparam int TMR_W      = 13;

   localparam logic [2:0] STG_LOAD  = 3'd0;
   localparam logic [2:0] STG_CONV1 = 3'd1;
   localparam logic [2:0] STG_POOL1 = 3'd2;
   localparam logic [2:0] STG_CONV2 = 3'd3;
   localparam logic [2:0] STG_POOL2 = 3'd4;
   localparam logic [2:0] STG_FC    = 3'd5;

   typedef struct packed {
      logic [2:0] conv1;
      logic [2:0] pool1;
      logic [2:0] conv2;
      logic [2:0] pool2;
      logic [2:0] fc;
   } pass_cfg_t;

   // Image load always runs once; a configured count of zero behaves as one.
   function automatic logic [2:0] passes_for(input logic [2:0] stage, input pass_cfg_t cfg);
      logic [2:0] n;
      case (stage)
         STG_CONV1: n = cfg.conv1;
         STG_POOL1: n = cfg.pool1;
         STG_CONV2: n = cfg.conv2;
         STG_POOL2: n = cfg.pool2;
         STG_FC:    n = cfg.fc;
         default:   n = 3'd1;
      endcase
      return (n == 3'd0) ? 3'd1 : n;
   endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Host/counter-facing signal bundle of the layer sequencer.
// slave = sequencer side, master = host and layer counters.
interface cnn_layer_sequencer_if;
   import cnn_seq_pkg::*;

   logic                  start;
   logic                  abort;
   logic [NUM_STAGES-1:0] stage_done;
   logic [NUM_STAGES-1:0] stage_clr;
   logic [NUM_STAGES-1:0] stage_en;
   logic [2:0]            stage_idx;
   logic [2:0]            pass_idx;
   logic                  busy;
   logic                  done;
   logic                  wdog_err;

   modport master (
      output start, abort, stage_done,
      input  stage_clr, stage_en, stage_idx, pass_idx, busy, done, wdog_err
   );

   modport slave (
      input  start, abort, stage_done,
      output stage_clr, stage_en, stage_idx, pass_idx, busy, done, wdog_err
   );

endinterface

// File: rtl/seq_cycle_timer.sv
// Loadable down-counter that saturates at zero; shared between the
// inter-pass drain interval and the per-pass watchdog.
module seq_cycle_timer
   import cnn_seq_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Top-level control FSM stepping the per-layer address counters through every
// stage and pass. Optional run watchdog enabled by defining SEQ_WATCHDOG_EN.
module cnn_layer_sequencer
   import cnn_seq_pkg::*;
#(
   parameter int DRAIN_CYC    = 4,
   parameter int CONV1_PASSES = 3,
   parameter int POOL1_PASSES = 3,
   parameter int CONV2_PASSES = 4,
   parameter int POOL2_PASSES = 4,
   parameter int FC_PASSES    = 5,
   parameter int WDOG_CYC     = 8192
) (
   input logic                  clk,
   input logic                  reset,
   cnn_layer_sequencer_if.slave bus
);

   localparam pass_cfg_t CFG = '{
      conv1: 3'(CONV1_PASSES),
      pool1: 3'(POOL1_PASSES),
      conv2: 3'(CONV2_PASSES),
      pool2: 3'(POOL2_PASSES),
      fc:    3'(FC_PASSES)
   };
   localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
   localparam logic [TMR_W-1:0] WDOG_LOAD  = TMR_W'(WDOG_CYC - 1);

   seq_state_t            state_q, state_d;
   logic [2:0]            stage_idx_q, stage_idx_d;
   logic [2:0]            pass_idx_q, pass_idx_d;
   logic                  run_first_q, run_first_d;
   logic [NUM_STAGES-1:0] stage_clr_q, stage_clr_d;
   logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  tmr_load, tmr_dec, tmr_zero;
   logic [TMR_W-1:0]      tmr_val;
   logic                  run_done;

   // The first RUN cycle may still see the previous pass's done level.
   assign run_done = !run_first_q && bus.stage_done[stage_idx_q];

   seq_cycle_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d     = state_q;
      stage_idx_d = stage_idx_q;
      pass_idx_d  = pass_idx_q;
      run_first_d = 1'b0;
      tmr_load    = 1'b0;
      tmr_dec     = 1'b0;
      tmr_val     = WDOG_LOAD;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d     = S_CLEAR;
               stage_idx_d = '0;
               pass_idx_d  = '0;
            end
         end
         S_CLEAR: begin
            state_d     = S_RUN;
            run_first_d = 1'b1;
            tmr_load    = 1'b1;
         end
         S_RUN: begin
            if (run_done) begin
               if (DRAIN_CYC > 0) begin
                  state_d  = S_DRAIN;
                  tmr_load = 1'b1;
                  tmr_val  = DRAIN_LOAD;
               end else begin
                  state_d = S_NEXT;
               end
            end
`ifdef SEQ_WATCHDOG_EN
            else if (tmr_zero) begin
               state_d     = S_IDLE;
               stage_idx_d = '0;
               pass_idx_d  = '0;
            end else begin
               tmr_dec = 1'b1;
            end
`endif
         end
         S_DRAIN: begin
            if (tmr_zero) state_d = S_NEXT;
            else          tmr_dec = 1'b1;
         end
         S_NEXT: begin
            if (pass_idx_q < passes_for(stage_idx_q, CFG) - 3'd1) begin
               pass_idx_d = pass_idx_q + 3'd1;
               state_d    = S_CLEAR;
            end else if (stage_idx_q < STG_FC) begin
               stage_idx_d = stage_idx_q + 3'd1;
               pass_idx_d  = '0;
               state_d     = S_CLEAR;
            end else begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d     = S_IDLE;
            stage_idx_d = '0;
            pass_idx_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.abort) begin
         state_d     = S_IDLE;
         stage_idx_d = '0;
         pass_idx_d  = '0;
         run_first_d = 1'b0;
         tmr_load    = 1'b0;
         tmr_dec     = 1'b0;
      end

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      stage_clr_d = '0;
      stage_en_d  = '0;
      if (state_d == S_CLEAR) stage_clr_d = NUM_STAGES'(1) << stage_idx_d;
      if (state_d == S_RUN)   stage_en_d  = NUM_STAGES'(1) << stage_idx_d;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FINISH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         stage_idx_q <= '0;
         pass_idx_q  <= '0;
         run_first_q <= 1'b0;
         stage_clr_q <= '0;
         stage_en_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stage_idx_q <= stage_idx_d;
         pass_idx_q  <= pass_idx_d;
         run_first_q <= run_first_d;
         stage_clr_q <= stage_clr_d;
         stage_en_q  <= stage_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef SEQ_WATCHDOG_EN
   logic wdog_err_q, wdog_err_d;

   always_comb begin
      wdog_err_d = wdog_err_q;
      if (!bus.abort) begin
         if (state_q == S_IDLE && bus.start)
            wdog_err_d = 1'b0;
         else if (state_q == S_RUN && !run_done && tmr_zero)
            wdog_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wdog_err_q <= 1'b0;
      else       wdog_err_q <= wdog_err_d;
   end

   assign bus.wdog_err = wdog_err_q;
`else
   assign bus.wdog_err = 1'b0;
`endif

   assign bus.stage_clr = stage_clr_q;
   assign bus.stage_en  = stage_en_q;
   assign bus.stage_idx = stage_idx_q;
   assign bus.pass_idx  = pass_idx_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: full inferences, stale/stray done,
// ignored start, abort, async reset and (with SEQ_WATCHDOG_EN) the watchdog.
module tb_cnn_layer_sequencer;
   import cnn_seq_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   npass [6] = '{1, 3, 1, 2, 1, 1};

   cnn_layer_sequencer_if bus ();

   cnn_layer_sequencer #(
      .DRAIN_CYC    (2),
      .CONV1_PASSES (3),
      .POOL1_PASSES (1),
      .CONV2_PASSES (2),
      .POOL2_PASSES (1),
      .FC_PASSES    (1),
      .WDOG_CYC     (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] oh(input int s);
      logic [5:0] one;
      one = 6'd1;
      return one << s;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_io(input string tag, input logic [5:0] clr, input logic [5:0] en,
                         input logic b, input logic d);
      chk({tag, ".clr"},  8'(bus.stage_clr), 8'(clr));
      chk({tag, ".en"},   8'(bus.stage_en),  8'(en));
      chk({tag, ".busy"}, 8'(bus.busy),      8'(b));
      chk({tag, ".done"}, 8'(bus.done),      8'(d));
   endtask

   task automatic chk_idx(input string tag, input int s, input int p);
      chk({tag, ".stage"}, 8'(bus.stage_idx), 8'(s));
      chk({tag, ".pass"},  8'(bus.pass_idx),  8'(p));
   endtask

   // Entered in the CLEAR cycle of the pass; returns in the cycle after NEXT.
   task automatic run_pass(input int s, input int p, input logic [5:0] noise,
                           input bit keep, input bit poke_start, input bit do_abort);
      string pre;
      pre = $sformatf("s%0dp%0d", s, p);
      $display("pass: stage %0d pass %0d", s, p);
      chk_io({pre, ".clear"}, oh(s), 6'd0, 1'b1, 1'b0);
      chk_idx({pre, ".clear"}, s, p);
      tick();
      chk_io({pre, ".run0"}, 6'd0, oh(s), 1'b1, 1'b0);
      tick();
      chk_io({pre, ".run1"}, 6'd0, oh(s), 1'b1, 1'b0);
      bus.stage_done = noise;
      if (poke_start) bus.start = 1'b1;
      if (do_abort) begin
         bus.abort = 1'b1;
         tick();
         chk_io({pre, ".abort"}, 6'd0, 6'd0, 1'b0, 1'b0);
         chk_idx({pre, ".abort"}, 0, 0);
         bus.abort      = 1'b0;
         bus.stage_done = '0;
         return;
      end
      tick();
      bus.start = 1'b0;
      chk_io({pre, ".run2"}, 6'd0, oh(s), 1'b1, 1'b0);
      chk_idx({pre, ".run2"}, s, p);
      tick();
      chk_io({pre, ".run3"}, 6'd0, oh(s), 1'b1, 1'b0);
      bus.stage_done = noise | oh(s);
      tick();
      chk_io({pre, ".drain0"}, 6'd0, 6'd0, 1'b1, 1'b0);
      if (!keep) bus.stage_done = '0;
      tick();
      chk_io({pre, ".drain1"}, 6'd0, 6'd0, 1'b1, 1'b0);
      tick();
      chk_io({pre, ".next"}, 6'd0, 6'd0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic run_inference(input bit abort_c2p1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int s = 0; s < 6; s++) begin
         for (int p = 0; p < npass[s]; p++) begin
            if (abort_c2p1 && s == 3 && p == 1) begin
               run_pass(s, p, 6'd0, 1'b0, 1'b0, 1'b1);
               return;
            end
            run_pass(s, p, (s == 2) ? 6'b010000 : 6'd0, (s == 1 && p < 2), (s == 0), 1'b0);
         end
      end
      $display("inference complete");
      chk_io("finish", 6'd0, 6'd0, 1'b1, 1'b1);
      tick();
      chk_io("idle_after", 6'd0, 6'd0, 1'b0, 1'b0);
      chk_idx("idle_after", 0, 0);
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.stage_done = '0;

      repeat (3) tick();
      chk_io("reset", 6'd0, 6'd0, 1'b0, 1'b0);
      chk_idx("reset", 0, 0);
      chk("reset.wdog", 8'(bus.wdog_err), 8'd0);
      reset = 1'b0;
      tick();
      chk_io("idle", 6'd0, 6'd0, 1'b0, 1'b0);

      run_inference(1'b0);

      run_inference(1'b1);
      tick();
      chk_io("post_abort", 6'd0, 6'd0, 1'b0, 1'b0);

      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk_io("abort_start", 6'd0, 6'd0, 1'b0, 1'b0);
      tick();
      chk_io("abort_start2", 6'd0, 6'd0, 1'b0, 1'b0);
      $display("abort+start in idle held idle");

      run_inference(1'b0);

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk_io("pre_areset", 6'd0, 6'd1, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk_io("areset", 6'd0, 6'd0, 1'b0, 1'b0);
      chk_idx("areset", 0, 0);
      tick();
      reset = 1'b0;
      tick();
      chk_io("areset_idle", 6'd0, 6'd0, 1'b0, 1'b0);
      $display("async reset mid-run");

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk_io("wd.clear", 6'd1, 6'd0, 1'b1, 1'b0);
`ifdef SEQ_WATCHDOG_EN
      for (int i = 0; i < 16; i++) begin
         tick();
         chk_io($sformatf("wd.run%0d", i), 6'd0, 6'd1, 1'b1, 1'b0);
      end
      tick();
      chk_io("wd.trip", 6'd0, 6'd0, 1'b0, 1'b0);
      chk("wd.trip.err", 8'(bus.wdog_err), 8'd1);
      tick();
      chk("wd.nodone", 8'(bus.done), 8'd0);
      chk("wd.sticky", 8'(bus.wdog_err), 8'd1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("wd.restart.err", 8'(bus.wdog_err), 8'd0);
      chk_io("wd.restart", 6'd1, 6'd0, 1'b1, 1'b0);
`else
      for (int i = 0; i < 20; i++) tick();
      chk_io("nowd.stall", 6'd0, 6'd1, 1'b1, 1'b0);
      chk("nowd.err", 8'(bus.wdog_err), 8'd0);
`endif
      $display("watchdog scenario");
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk_io("final_idle", 6'd0, 6'd0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Top-level control FSM for the digit-recognition pipeline.
- Runs the per-layer address counters in order: image load, conv1, pool1, conv2, pool2, fc.
- Gives each counter a clear pulse and then an enable window, and re-runs a stage once per pass (output-map group).
- Waits a fixed drain interval between passes so the MAC pipeline empties; reports busy/done to the host interface.

Parameters:
- DRAIN_CYC, 4, idle cycles after each pass before the next clear (0 = no drain state).
- CONV1_PASSES, 3, conv1 passes (2 maps per pass).
- POOL1_PASSES, 3, pool1 passes.
- CONV2_PASSES, 4, conv2 passes.
- POOL2_PASSES, 4, pool2 passes.
- FC_PASSES, 5, fc passes (2 class outputs per pass).
- WDOG_CYC, 8192, max RUN cycles per pass (used only with the watchdog option).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one inference; accepted only in IDLE
- abort  in  1  synchronous abort; return to IDLE
- stage_done  in  6  done level from each counter; bit0 = load … bit5 = fc
- stage_clr  out  6  one-hot one-cycle clear pulse to the selected counter's reset
- stage_en  out  6  one-hot enable to the active counter
- stage_idx  out  3  current stage 0..5
- pass_idx  out  3  current pass within the stage
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when inference completes
- wdog_err  out  1  sticky watchdog error (watchdog option only; tied 0 otherwise)

Behaviour:
- Reset values: all outputs 0, state IDLE, stage_idx = 0, pass_idx = 0, drain counter 0.
- States: IDLE, CLEAR, RUN, DRAIN, NEXT, FINISH. All outputs are registered.
- IDLE:
  - start=1 at cycle t → CLEAR at t+1 with stage_idx = 0, pass_idx = 0.
  - start is ignored in every other state.
- CLEAR: stage_clr[stage_idx] = 1 for exactly 1 cycle, then RUN.
- RUN:
  - stage_en[stage_idx] = 1.
  - stage_done[stage_idx] is sampled only in RUN and only from the second RUN cycle, so a stale done before the counter clears is ignored.
  - Done seen at cycle k → stage_en is 0 at k+1 and state is DRAIN (or NEXT if DRAIN_CYC = 0).
  - stage_done bits of non-active stages are ignored.
- DRAIN: counts DRAIN_CYC cycles with all enables 0, then NEXT.
- NEXT (1 cycle, decision only):
  - pass_idx < passes(stage_idx) − 1 → pass_idx + 1, CLEAR.
  - else if stage_idx < 5 → stage_idx + 1, pass_idx = 0, CLEAR.
  - else → FINISH.
  - The load stage always has exactly 1 pass.
- FINISH: done = 1 for 1 cycle; then IDLE with stage_idx and pass_idx reset to 0.
- Latency from start to the first enable is 2 cycles.
- abort has priority over every transition:
  - Next cycle: state IDLE, stage_en = 0, stage_clr = 0, no done pulse, indices reset to 0.
  - abort together with start in IDLE → remain IDLE.
- An async reset mid-operation returns everything to reset values immediately.
- Pass counts of 0 are illegal; they are treated as 1.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined:
  - A 13-bit counter clears on entry to RUN and increments each RUN cycle.
  - Reaching WDOG_CYC without done → wdog_err set (sticky until reset or next accepted start), all enables dropped, state IDLE, no done pulse.
- Undefined: no counter is built, wdog_err is tied 0, and RUN waits indefinitely.

Decomposition:
- Package cnn_seq_pkg holds:
  - typedef enum seq_state_t;
  - stage index constants STG_LOAD..STG_FC;
  - NUM_STAGES = 6;
  - function passes_for(stage) returning the per-stage pass count.
- One natural sub-module: seq_cycle_timer, a loadable down-counter shared by the DRAIN count and the watchdog count.

Test Plan:
- Use DRAIN_CYC=2, all pass counts 1. Pulse start, then assert each stage_done 3 cycles after its enable rises. Expect:
  - clr/en one-hot in order bit0..bit5;
  - en drops 1 cycle after done;
  - 2 drain cycles, then 1 NEXT cycle before the next clr;
  - a single done pulse, then busy=0.
- Set CONV1_PASSES=3 and hold stage_done[1]=1 from the previous pass. Expect:
  - stage_clr[1] pulsed 3 times and pass_idx going 0,1,2;
  - the stale done ignored on the first RUN cycle of each pass.
- Assert abort during conv2 RUN, pass 1. Expect next cycle: stage_en = 0, busy = 0, no done. A new start then restarts at stage 0, pass 0.
- Assert stage_done[4] while stage 2 is running. Expect no effect.
- Assert start while busy. Expect it to be ignored, with no restart.
- With SEQ_WATCHDOG_EN and WDOG_CYC=16, never assert stage_done[0]. Expect wdog_err = 1 after 16 RUN cycles, state IDLE, done never pulsed.
